// File: rtl/mod13_seq_monitor.sv
// -----------------------------------------------------------------------------
// mod13_seq_monitor
//
// Downstream checker and extender for a mod-MOD up-counter. It samples the
// counter output together with the load strobe and load data that the counter
// itself receives. On every edge it predicts the value the counter should show
// and compares the live sample against that prediction.
//
// It raises a sticky error flag and records the offending and expected values.
// It emits a one-cycle carry pulse on every natural (MOD-1)->0 rollover, and it
// keeps saturating counts of rollovers and mismatches.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : synchronous active-high reset, discards all history
//   load       : load strobe also driven to the counter
//   din        : load data also driven to the counter
//   cntr       : counter output being monitored
//   clr_err    : synchronous clear of err/err_cnt, forces a resync edge
//   wrap_pulse : one-cycle pulse per accepted rollover
//   wrap_cnt   : saturating rollover count
//   err        : sticky error flag
//   err_cnt    : saturating mismatch count
//   bad_val    : cntr value at the most recent mismatch
//   exp_val    : predicted value at the most recent mismatch
// -----------------------------------------------------------------------------
module mod13_seq_monitor #(
    parameter int MOD    = 13,
    parameter int CW     = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CW-1:0]     din,
    input  logic [CW-1:0]     cntr,
    input  logic              clr_err,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [CW-1:0]     bad_val,
    output logic [CW-1:0]     exp_val
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [CW-1:0]     LAST_C     = CW'(MOD - 1);
    localparam logic [CW-1:0]     ZERO_C     = {CW{1'b0}};
    localparam logic [CW-1:0]     ONE_C      = CW'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE_C = WRAP_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX_C = {WRAP_W{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_ONE_C  = ERR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX_C  = {ERR_W{1'b1}};

    state_t              state_r;
    logic [CW-1:0]       prev_q_r;
    logic                load_q_r;
    logic [CW-1:0]       din_q_r;
    logic                wrap_pulse_r;
    logic [WRAP_W-1:0]   wrap_cnt_r;
    logic                err_r;
    logic [ERR_W-1:0]    err_cnt_r;
    logic [CW-1:0]       bad_val_r;
    logic [CW-1:0]       exp_val_r;

    logic [CW-1:0]       exp_s;
    logic                mismatch_s;
    logic                wrap_s;
    logic                checking_s;

    // Predict the counter value for this edge from the previous sample and load.
    always_comb begin
        exp_s = ZERO_C;
        if (load_q_r) begin
            exp_s = din_q_r;
        end else if (prev_q_r == LAST_C) begin
            exp_s = ZERO_C;
        end else begin
            exp_s = prev_q_r + ONE_C;
        end
    end

    // Classify the current sample: mismatch/range error, natural rollover, checking window.
    always_comb begin
        // An out-of-range sample is always an error, even if it matches a bad load.
        mismatch_s = (cntr != exp_s) || (cntr > LAST_C);
        // Only an unloaded step from MOD-1 to 0 counts as a carry.
        wrap_s     = (!load_q_r) && (prev_q_r == LAST_C) && (cntr == ZERO_C);
        checking_s = (state_r == ST_TRACK) || (state_r == ST_FAULT);
    end

    // Main sequencer: sample history, state machine, wrap and error accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_SYNC;
            prev_q_r     <= ZERO_C;
            load_q_r     <= 1'b0;
            din_q_r      <= ZERO_C;
            wrap_pulse_r <= 1'b0;
            wrap_cnt_r   <= {WRAP_W{1'b0}};
            err_r        <= 1'b0;
            err_cnt_r    <= {ERR_W{1'b0}};
            bad_val_r    <= ZERO_C;
            exp_val_r    <= ZERO_C;
        end else begin
            prev_q_r     <= cntr;
            load_q_r     <= load;
            din_q_r      <= din;
            wrap_pulse_r <= 1'b0;

            if (checking_s && wrap_s) begin
                wrap_pulse_r <= 1'b1;
                if (wrap_cnt_r != WRAP_MAX_C) begin
                    wrap_cnt_r <= wrap_cnt_r + WRAP_ONE_C;
                end
            end

            if (clr_err) begin
                // Clear wins over any mismatch seen at this same edge.
                err_r     <= 1'b0;
                err_cnt_r <= {ERR_W{1'b0}};
                state_r   <= ST_SYNC;
            end else begin
                case (state_r)
                    ST_SYNC: begin
                        // Capture-only edge: the prediction has no valid history yet.
                        state_r <= ST_TRACK;
                    end
                    ST_TRACK, ST_FAULT: begin
                        if (mismatch_s) begin
                            err_r     <= 1'b1;
                            bad_val_r <= cntr;
                            exp_val_r <= exp_s;
                            state_r   <= ST_FAULT;
                            if (err_cnt_r != ERR_MAX_C) begin
                                err_cnt_r <= err_cnt_r + ERR_ONE_C;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign wrap_pulse = wrap_pulse_r;
    assign wrap_cnt   = wrap_cnt_r;
    assign err        = err_r;
    assign err_cnt    = err_cnt_r;
    assign bad_val    = bad_val_r;
    assign exp_val    = exp_val_r;

endmodule

// File: tb/tb_mod13_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_mod13_seq_monitor
//
// Directed bench for mod13_seq_monitor. The bench plays the role of the
// monitored counter and drives cntr/load/din directly, so that faults can be
// injected by driving off-sequence values.
//
// A second instance with 2-bit accumulators shares the same stimulus and is
// used to observe saturation. All expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_mod13_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] din;
    logic [3:0] cntr;
    logic       clr_err;

    logic       wrap_pulse;
    logic [7:0] wrap_cnt;
    logic       err;
    logic [7:0] err_cnt;
    logic [3:0] bad_val;
    logic [3:0] exp_val;

    logic       s_wrap_pulse;
    logic [1:0] s_wrap_cnt;
    logic       s_err;
    logic [1:0] s_err_cnt;
    logic [3:0] s_bad_val;
    logic [3:0] s_exp_val;

    int compared_cnt   = 0;
    int mismatched_cnt = 0;

    always #5 clk = ~clk;

    mod13_seq_monitor dut (
        .clk(clk), .rst(rst), .load(load), .din(din), .cntr(cntr),
        .clr_err(clr_err), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt),
        .err(err), .err_cnt(err_cnt), .bad_val(bad_val), .exp_val(exp_val)
    );

    mod13_seq_monitor #(.WRAP_W(2), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .load(load), .din(din), .cntr(cntr),
        .clr_err(clr_err), .wrap_pulse(s_wrap_pulse), .wrap_cnt(s_wrap_cnt),
        .err(s_err), .err_cnt(s_err_cnt), .bad_val(s_bad_val), .exp_val(s_exp_val)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared_cnt++;
        if (obs !== expv) begin
            mismatched_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Present one sample to both monitors and step past the next rising edge.
    task automatic cyc(input logic [3:0] c, input logic l, input logic [3:0] d, input logic cl);
        cntr    = c;
        load    = l;
        din     = d;
        clr_err = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] prev;
        logic       first;
        logic       ep;

        rst = 1'b1;
        cyc(4'd0, 1'b0, 4'd0, 1'b0);
        cyc(4'd0, 1'b0, 4'd0, 1'b0);
        chk_eq("rst_wrap_pulse", wrap_pulse, 0);
        chk_eq("rst_wrap_cnt",   wrap_cnt,   0);
        chk_eq("rst_err",        err,        0);
        chk_eq("rst_err_cnt",    err_cnt,    0);
        chk_eq("rst_bad_val",    bad_val,    0);
        chk_eq("rst_exp_val",    exp_val,    0);
        rst = 1'b0;

        // Free run: 0..12, 0..12, 0..3 -> rollovers on cycles 14 and 27.
        cur   = 4'd0;
        prev  = 4'd0;
        first = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc(cur, 1'b0, 4'd0, 1'b0);
            ep = !first && (prev == 4'd12) && (cur == 4'd0);
            chk_eq("free_wrap_pulse", wrap_pulse, ep);
            prev  = cur;
            first = 1'b0;
            cur   = (cur == 4'd12) ? 4'd0 : cur + 4'd1;
        end
        chk_eq("free_wrap_cnt", wrap_cnt, 2);
        chk_eq("free_err",      err,      0);

        // Load 9 while at 5, then 9,10,11,12,0 must be accepted with one wrap.
        cyc(4'd4, 1'b0, 4'd0, 1'b0);
        cyc(4'd5, 1'b1, 4'd9, 1'b0);
        cyc(4'd9,  1'b0, 4'd0, 1'b0);
        cyc(4'd10, 1'b0, 4'd0, 1'b0);
        cyc(4'd11, 1'b0, 4'd0, 1'b0);
        cyc(4'd12, 1'b0, 4'd0, 1'b0);
        chk_eq("load_pulse_before_wrap", wrap_pulse, 0);
        cyc(4'd0,  1'b0, 4'd0, 1'b0);
        chk_eq("load_wrap_pulse", wrap_pulse, 1);
        chk_eq("load_wrap_cnt",   wrap_cnt,   3);
        chk_eq("load_err",        err,        0);

        // Load 0 while at 12 moves to 0 but is not a rollover.
        for (int v = 1; v <= 11; v++) cyc(4'(v), 1'b0, 4'd0, 1'b0);
        cyc(4'd12, 1'b1, 4'd0, 1'b0);
        cyc(4'd0,  1'b0, 4'd0, 1'b0);
        chk_eq("loadzero_wrap_pulse", wrap_pulse, 0);
        chk_eq("loadzero_wrap_cnt",   wrap_cnt,   3);
        chk_eq("loadzero_err",        err,        0);

        // Fault: 7 followed by 3 instead of 8.
        for (int v = 1; v <= 7; v++) cyc(4'(v), 1'b0, 4'd0, 1'b0);
        cyc(4'd3, 1'b0, 4'd0, 1'b0);
        chk_eq("fault_err",     err,     1);
        chk_eq("fault_err_cnt", err_cnt, 1);
        chk_eq("fault_bad_val", bad_val, 3);
        chk_eq("fault_exp_val", exp_val, 8);
        cyc(4'd4, 1'b0, 4'd0, 1'b0);
        chk_eq("fault_follow_err_cnt", err_cnt, 1);
        chk_eq("fault_follow_err",     err,     1);

        // Out-of-range load of 13, echoed by the counter.
        cyc(4'd5,  1'b1, 4'd13, 1'b0);
        cyc(4'd13, 1'b0, 4'd0,  1'b0);
        chk_eq("oor_err_cnt", err_cnt, 2);
        chk_eq("oor_bad_val", bad_val, 13);
        chk_eq("oor_exp_val", exp_val, 13);
        chk_eq("oor_err",     err,     1);

        // Clear on the same edge as a mismatch (expected 14, sees 0).
        cyc(4'd0, 1'b0, 4'd0, 1'b1);
        chk_eq("clr_err",         err,       0);
        chk_eq("clr_err_cnt",     err_cnt,   0);
        chk_eq("clr_bad_val_kept", bad_val,  13);
        chk_eq("clr_sat_err_cnt", s_err_cnt, 0);
        cyc(4'd7, 1'b0, 4'd0, 1'b0);
        chk_eq("sync_jump_err",     err,     0);
        chk_eq("sync_jump_err_cnt", err_cnt, 0);
        cyc(4'd8, 1'b0, 4'd0, 1'b0);
        chk_eq("resync_inc_err", err, 0);

        // Five mismatches: main counts 5, 2-bit instance saturates at 3.
        for (int k = 0; k < 5; k++) cyc(4'd3, 1'b0, 4'd0, 1'b0);
        chk_eq("sat_main_err_cnt", err_cnt,    5);
        chk_eq("sat_err_cnt",      s_err_cnt,  3);
        chk_eq("sat_err",          s_err,      1);
        chk_eq("sat_exp_val",      exp_val,    4);
        chk_eq("sat_wrap_cnt",     s_wrap_cnt, 3);

        // Mid-run reset clears everything; first post-reset sample is unchecked.
        rst = 1'b1;
        cyc(4'd3, 1'b0, 4'd0, 1'b0);
        chk_eq("mrst_wrap_pulse", wrap_pulse, 0);
        chk_eq("mrst_wrap_cnt",   wrap_cnt,   0);
        chk_eq("mrst_err",        err,        0);
        chk_eq("mrst_err_cnt",    err_cnt,    0);
        chk_eq("mrst_bad_val",    bad_val,    0);
        chk_eq("mrst_exp_val",    exp_val,    0);
        chk_eq("mrst_sat_err_cnt", s_err_cnt, 0);
        rst = 1'b0;
        cyc(4'd9,  1'b0, 4'd0, 1'b0);
        chk_eq("post_rst_unchecked", err, 0);
        cyc(4'd10, 1'b0, 4'd0, 1'b0);
        chk_eq("post_rst_inc", err, 0);
        cyc(4'd2,  1'b0, 4'd0, 1'b0);
        chk_eq("post_rst_fault_err",     err,     1);
        chk_eq("post_rst_fault_err_cnt", err_cnt, 1);
        chk_eq("post_rst_fault_bad_val", bad_val, 2);
        chk_eq("post_rst_fault_exp_val", exp_val, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
        $finish;
    end

endmodule

// File: doc/mod13_seq_monitor.md
Name: mod13_seq_monitor

Overview:
- Downstream checker and extender for the mod-13 up-counter.
- Samples the counter's 4-bit output together with the same load/din stimulus the counter receives, and predicts the next legal value each cycle.
- Flags sequence and range violations, emits a one-cycle wrap (carry) pulse on each 12->0 rollover, and accumulates wraps and errors in saturating counters.
- Used as a cascade stage (wrap count extends the count range) and as an in-system self-check.

Parameters:
- MOD, 13, counter modulus; legal counter values are 0..MOD-1.
- CW, 4, counter value width.
- WRAP_W, 8, width of the wrap accumulator.
- ERR_W, 8, width of the error accumulator.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  same load strobe driven to the counter.
- din  in  CW  same load data driven to the counter.
- cntr  in  CW  counter output being monitored.
- clr_err  in  1  synchronous clear of the error state and err_cnt.
- wrap_pulse  out  1  one-cycle pulse per accepted 12->0 rollover.
- wrap_cnt  out  WRAP_W  number of rollovers, saturating.
- err  out  1  sticky error flag.
- err_cnt  out  ERR_W  number of mismatching samples, saturating.
- bad_val  out  CW  cntr value of the most recent mismatch.
- exp_val  out  CW  expected value at the most recent mismatch.

Behaviour:
- Reset (rst=1 at an edge):
  - state<=SYNC.
  - All outputs and internal registers 0: wrap_pulse=0, wrap_cnt=0, err=0, err_cnt=0, bad_val=0, exp_val=0, prev_q=0, load_q=0, din_q=0.
  - Reset mid-operation discards all history.
- Every non-reset edge registers prev_q<=cntr, load_q<=load, din_q<=din.
- Expected value computed at each edge:
  - exp = load_q ? din_q : (prev_q==MOD-1 ? 0 : prev_q+1).
  - CW-bit arithmetic; no width growth.
- Mismatch at an edge = (cntr != exp) OR (cntr > MOD-1).
  - A load of din > MOD-1 therefore always produces a mismatch at the following edge (out-of-range).
- State machine:
  - SYNC: capture the sample only; no check and no wrap detection. Next state is TRACK. Gives exactly one unchecked edge after reset or clear.
  - TRACK: check every edge. On a mismatch: err<=1, err_cnt+1, bad_val<=cntr, exp_val<=exp, next state FAULT.
  - FAULT: err held at 1. Checking continues; each further mismatch increments err_cnt and updates bad_val/exp_val. Leaves only via clr_err or rst.
- clr_err=1 (not in reset):
  - Effects: err<=0, err_cnt<=0, next state SYNC.
  - Takes precedence over a mismatch at the same edge; that mismatch is not counted.
  - wrap_cnt, bad_val and exp_val are unaffected.
- Wrap detection (TRACK or FAULT only):
  - Condition: load_q==0, prev_q==MOD-1, cntr==0.
  - Result: wrap_pulse<=1 for exactly one cycle; wrap_cnt increments.
  - A load that moves the count from 12 to 0 is not a wrap.
  - A wrap sample that is also a mismatch cannot occur by construction.
- Saturation: wrap_cnt and err_cnt hold at all-ones and never roll over.
- Latency: all outputs are registered. A fault present on cntr before edge t is visible on err/err_cnt immediately after edge t. wrap_pulse is high in the cycle following the edge at which cntr==0 was sampled.
- rst has priority over clr_err.

Test Plan:
- Free run after reset: 30 cycles, no load -> err=0; wrap_pulse high for one cycle at each 12->0 rollover; wrap_cnt=2 after the second rollover.
- Load sequencing:
  - Counter at 5, load=1/din=9 for one cycle -> cntr 9,10,11,12,0 accepted; err=0; one wrap pulse.
  - With the counter at 12, load din=0 -> no wrap pulse and wrap_cnt unchanged.
- Fault injection: force cntr from 7 to 3 for one sample -> err=1, err_cnt=1, bad_val=3, exp_val=8, state FAULT. The next sample 4 is correct relative to 3 (expected prev+1), so err_cnt stays 1 and err stays high.
- Out-of-range: load din=13 -> the next edge flags a mismatch with bad_val=13 (if the DUT holds 13) or exp_val=13 otherwise; err=1.
- Clear precedence and resync: clr_err=1 on the same edge as a forced mismatch -> err=0, err_cnt=0, and the following edge is unchecked. A deliberate jump during that SYNC edge is not flagged; the next legal increment passes.
- Saturation and reset:
  - With ERR_W=2, inject 5 mismatches -> err_cnt=3.
  - Assert rst mid-run -> every output reads 0 the cycle after, and the first post-reset sample is unchecked.
